// File: rtl/line_sensor_packetizer.sv
// Frames line-sensor pixel streams into AXI-Stream packets (raw pixel pairs or ROI moments)
// through an output FIFO that admits or drops each frame whole.
module line_sensor_packetizer #(
  parameter int PIX_W      = 12,
  parameter int NUM_PIXELS = 1024,
  parameter int IDX_W      = 10,
  parameter int ACC_W      = 48,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic             master_clock,
  input  logic             resetn,
  input  logic             mode,
  input  logic [IDX_W-1:0] roi_start,
  input  logic [IDX_W-1:0] roi_end,
  input  logic [15:0]      number_of_packet,
  input  logic [PIX_W-1:0] pix_data,
  input  logic [IDX_W-1:0] pix_index,
  input  logic             pix_valid,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [31:0]      frame_count,
  output logic [15:0]      drop_count,
  output logic             overflow
);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int RAW_NEED = NUM_PIXELS / 2 + 5;
  localparam int MOM_NEED = 8;
  localparam int PIPE     = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

  typedef enum logic [3:0] {
    IDLE, HDR, FCNT, TSTAMP, RAW, ACC, MOM, FOOTER, TLAST, DROP
  } state_t;

  state_t             state_q;
  logic [31:0]        ts_q, ts_cap_q, frame_count_q;
  logic [15:0]        drop_q, burst_q;
  logic               overflow_q, mode_q, pix_valid_q;
  logic [IDX_W-1:0]   roi_start_q, roi_end_q;
  logic [PIX_W-1:0]   even_q;
  logic [ACC_W-1:0]   c_q, d_q, c_d, d_d, sq;
  logic [1:0]         mom_cnt_q;
  logic [95:0]        mom_all;

  // Delay line lets the three header words go out before the first payload word.
  logic [PIPE-1:0]    pv_q;
  logic [IDX_W-1:0]   pi_q [PIPE];
  logic [PIX_W-1:0]   pd_q [PIPE];
  logic               dv, last;
  logic [IDX_W-1:0]   didx;
  logic [PIX_W-1:0]   dpix;

  always_ff @(posedge master_clock) begin
    if (!resetn) begin
      pix_valid_q <= 1'b0;
      pv_q        <= '0;
      for (int i = 0; i < PIPE; i++) begin
        pi_q[i] <= '0;
        pd_q[i] <= '0;
      end
    end else begin
      pix_valid_q <= pix_valid;
      pv_q        <= {pv_q[PIPE-2:0], pix_valid};
      pi_q[0]     <= pix_index;
      pd_q[0]     <= pix_data;
      for (int i = 1; i < PIPE; i++) begin
        pi_q[i] <= pi_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign dv   = pv_q[PIPE-1];
  assign didx = pi_q[PIPE-1];
  assign dpix = pd_q[PIPE-1];
  assign last = dv && (didx == LAST_IDX);

  always_comb begin
    sq  = ACC_W'(dpix) * ACC_W'(dpix);
    c_d = c_q;
    d_d = d_q;
    if (dv && (didx >= roi_start_q) && (didx <= roi_end_q)) begin
      c_d = c_q + sq;
      d_d = d_q + sq * ACC_W'(didx);
    end
  end

  assign mom_all = 96'({d_q, c_q});

  // FIFO of {tlast, tdata}, first-word fall-through via a forwarding registered read.
  logic [32:0]   mem [FIFO_DEPTH];
  logic [32:0]   rd_data_q, wr_data;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, free_words, need_words;
  logic          wr_en, pop;

  assign m_axis_tvalid = (count_q != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign rd_ptr_d      = rd_ptr_q + AW'(pop);
  assign free_words    = CW'(FIFO_DEPTH) - count_q;
  assign need_words    = mode ? CW'(MOM_NEED) : CW'(RAW_NEED);
  assign m_axis_tdata  = m_axis_tvalid ? rd_data_q[31:0] : 32'h0;
  assign m_axis_tlast  = m_axis_tvalid && rd_data_q[32];

  always_ff @(posedge master_clock) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
    rd_data_q <= (wr_en && (wr_ptr_q == rd_ptr_d)) ? wr_data : mem[rd_ptr_d];
  end

  always_ff @(posedge master_clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_q + CW'(wr_en) - CW'(pop);
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    case (state_q)
      HDR:    begin wr_en = 1'b1; wr_data = {1'b0, 32'hAAAA_AAAA}; end
      FCNT:   begin wr_en = 1'b1; wr_data = {1'b0, frame_count_q}; end
      TSTAMP: begin wr_en = 1'b1; wr_data = {1'b0, ts_cap_q}; end
      RAW: begin
        if (dv && didx[0]) begin
          wr_en   = 1'b1;
          wr_data = {1'b0, 16'(dpix), 16'(even_q)};
        end
      end
      MOM: begin
        wr_en = 1'b1;
        case (mom_cnt_q)
          2'd0:    wr_data = {1'b0, mom_all[31:0]};
          2'd1:    wr_data = {1'b0, mom_all[63:32]};
          default: wr_data = {1'b0, mom_all[95:64]};
        endcase
      end
      FOOTER: begin wr_en = 1'b1; wr_data = {1'b0, 32'h5555_5555}; end
      TLAST:  begin wr_en = 1'b1; wr_data = {1'b1, 32'hBBBB_BBBB}; end
      default: ;
    endcase
  end

  always_ff @(posedge master_clock) begin
    if (!resetn) begin
      state_q       <= IDLE;
      ts_q          <= '0;
      ts_cap_q      <= '0;
      frame_count_q <= '0;
      drop_q        <= '0;
      burst_q       <= '0;
      overflow_q    <= 1'b0;
      mode_q        <= 1'b0;
      roi_start_q   <= '0;
      roi_end_q     <= '0;
      even_q        <= '0;
      c_q           <= '0;
      d_q           <= '0;
      mom_cnt_q     <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      case (state_q)
        IDLE: begin
          if (pix_valid && !pix_valid_q) begin
            mode_q      <= mode;
            roi_start_q <= roi_start;
            roi_end_q   <= roi_end;
            ts_cap_q    <= ts_q;
            c_q         <= '0;
            d_q         <= '0;
            if (free_words >= need_words) begin
              state_q <= HDR;
            end else begin
              state_q    <= DROP;
              overflow_q <= 1'b1;
              if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
          end
        end
        HDR:    state_q <= FCNT;
        FCNT:   state_q <= TSTAMP;
        TSTAMP: state_q <= mode_q ? ACC : RAW;
        RAW: begin
          if (dv && !didx[0]) even_q <= dpix;
          if (last) state_q <= FOOTER;
        end
        ACC: begin
          c_q <= c_d;
          d_q <= d_d;
          if (last) begin
            state_q   <= MOM;
            mom_cnt_q <= '0;
          end
        end
        MOM: begin
          mom_cnt_q <= mom_cnt_q + 2'd1;
          if (mom_cnt_q == 2'd2) state_q <= FOOTER;
        end
        FOOTER: begin
          frame_count_q <= frame_count_q + 32'd1;
          if (burst_q < number_of_packet) begin
            burst_q <= burst_q + 16'd1;
            state_q <= IDLE;
          end else begin
            burst_q <= '0;
            state_q <= TLAST;
          end
        end
        TLAST: state_q <= IDLE;
        DROP:  if (last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_count = frame_count_q;
  assign drop_count  = drop_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_line_sensor_packetizer.sv
// Bench for line_sensor_packetizer: directed and randomized frames compared word-by-word
// against a packet-format reference model; backpressure hold is checked continuously.
module tb_line_sensor_packetizer;
  localparam int PIX_W = 12;
  localparam int NP    = 8;
  localparam int IDX_W = 3;
  localparam int ACC_W = 48;
  localparam int DEPTH = 16;

  logic             master_clock = 1'b0;
  logic             resetn;
  logic             mode;
  logic [IDX_W-1:0] roi_start, roi_end;
  logic [15:0]      number_of_packet;
  logic [PIX_W-1:0] pix_data;
  logic [IDX_W-1:0] pix_index;
  logic             pix_valid;
  logic [31:0]      m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic [31:0]      frame_count;
  logic [15:0]      drop_count;
  logic             overflow;

  line_sensor_packetizer #(
    .PIX_W(PIX_W), .NUM_PIXELS(NP), .IDX_W(IDX_W), .ACC_W(ACC_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .master_clock(master_clock), .resetn(resetn), .mode(mode),
    .roi_start(roi_start), .roi_end(roi_end), .number_of_packet(number_of_packet),
    .pix_data(pix_data), .pix_index(pix_index), .pix_valid(pix_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .frame_count(frame_count), .drop_count(drop_count),
    .overflow(overflow)
  );

  always #5 master_clock = ~master_clock;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rel_cyc = 0;
  logic [31:0] fc_m = '0;
  int          burst_m = 0;
  bit          rnd_rdy = 1'b0;
  logic [32:0] obs_q[$];
  logic [32:0] exp_q[$];
  logic [PIX_W-1:0] pixv [NP];
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word = '0;

  always @(posedge master_clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Collect popped words; a stalled word must stay put until accepted.
  always @(negedge master_clock) begin
    if (resetn && prev_stall)
      chk("hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_word});
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_word  = {m_axis_tlast, m_axis_tdata};
    if (m_axis_tvalid && m_axis_tready) obs_q.push_back({m_axis_tlast, m_axis_tdata});
  end

  initial begin
    forever begin
      @(posedge master_clock); #1;
      if (rnd_rdy) m_axis_tready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic model_frame(input bit m, input int rs, input int re, input logic [31:0] ts);
    logic [ACC_W-1:0] c, d, p2;
    exp_q.push_back({1'b0, 32'hAAAAAAAA});
    exp_q.push_back({1'b0, fc_m});
    exp_q.push_back({1'b0, ts});
    if (!m) begin
      for (int k = 0; k < NP / 2; k++)
        exp_q.push_back({1'b0, 16'(pixv[2*k+1]), 16'(pixv[2*k])});
    end else begin
      c = '0;
      d = '0;
      for (int i = 0; i < NP; i++) begin
        if (i >= rs && i <= re) begin
          p2 = ACC_W'(pixv[i]) * ACC_W'(pixv[i]);
          c  = c + p2;
          d  = d + p2 * ACC_W'(i);
        end
      end
      exp_q.push_back({1'b0, c[31:0]});
      exp_q.push_back({1'b0, d[15:0], c[47:32]});
      exp_q.push_back({1'b0, d[47:16]});
    end
    exp_q.push_back({1'b0, 32'h55555555});
    fc_m = fc_m + 32'd1;
    if (burst_m < int'(number_of_packet)) begin
      burst_m++;
    end else begin
      burst_m = 0;
      exp_q.push_back({1'b1, 32'hBBBBBBBB});
    end
  endtask

  task automatic send_frame(input bit m, input int rs, input int re, input bit admit);
    logic [31:0] ts;
    mode      = m;
    roi_start = IDX_W'(rs);
    roi_end   = IDX_W'(re);
    ts        = 32'(cyc - rel_cyc);
    if (admit) model_frame(m, rs, re, ts);
    for (int i = 0; i < NP; i++) begin
      pix_valid = 1'b1;
      pix_index = IDX_W'(i);
      pix_data  = pixv[i];
      @(posedge master_clock); #1;
    end
    pix_valid = 1'b0;
    repeat (12) begin @(posedge master_clock); #1; end
  endtask

  task automatic drain_check(input string tag);
    int t = 0;
    while (obs_q.size() < exp_q.size() && t < 2000) begin
      @(posedge master_clock); #1;
      t++;
    end
    repeat (5) begin @(posedge master_clock); #1; end
    chk({tag, "_len"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) chk(tag, 64'(obs_q[i]), 64'(exp_q[i]));
    $display("frame group %s: %0d words received, %0d expected", tag, obs_q.size(), exp_q.size());
  endtask

  task automatic clear_q();
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    resetn = 1'b0; mode = 1'b0; roi_start = '0; roi_end = '0; number_of_packet = '0;
    pix_data = '0; pix_index = '0; pix_valid = 1'b0; m_axis_tready = 1'b1;
    repeat (3) begin @(posedge master_clock); #1; end
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    resetn = 1'b1;
    rel_cyc = cyc;

    // Raw, ascending pixels, single-frame burst.
    for (int i = 0; i < NP; i++) pixv[i] = PIX_W'(i + 1);
    send_frame(1'b0, 0, 0, 1'b1);
    drain_check("raw_basic");
    if (obs_q.size() == 9) begin
      chk("raw_fcnt", 64'(obs_q[1]), 64'h0);
      chk("raw_pair0", 64'(obs_q[3]), 64'h0_00020001);
      chk("raw_pair3", 64'(obs_q[6]), 64'h0_00080007);
      chk("raw_tlast", 64'(obs_q[8]), 64'h1_BBBBBBBB);
    end
    clear_q();

    // Moments, flat image, full ROI: c=32, d=4*28=112.
    for (int i = 0; i < NP; i++) pixv[i] = PIX_W'(2);
    send_frame(1'b1, 0, NP - 1, 1'b1);
    drain_check("mom_flat");
    if (obs_q.size() == 8) begin
      chk("mom_flat_w0", 64'(obs_q[3]), 64'h0_00000020);
      chk("mom_flat_w1", 64'(obs_q[4]), 64'h0_00700000);
      chk("mom_flat_w2", 64'(obs_q[5]), 64'h0_00000000);
    end
    clear_q();

    // Single-pixel ROI at index 5 with value 3: c=9, d=45.
    for (int i = 0; i < NP; i++) pixv[i] = PIX_W'($urandom_range(0, 4095));
    pixv[5] = PIX_W'(3);
    send_frame(1'b1, 5, 5, 1'b1);
    drain_check("mom_roi5");
    if (obs_q.size() == 8) begin
      chk("mom_roi5_w0", 64'(obs_q[3]), 64'h0_00000009);
      chk("mom_roi5_w1", 64'(obs_q[4]), 64'h0_002D0000);
      chk("mom_roi5_w2", 64'(obs_q[5]), 64'h0_00000000);
    end
    clear_q();

    // Empty ROI (start > end).
    for (int i = 0; i < NP; i++) pixv[i] = PIX_W'($urandom_range(1, 4095));
    send_frame(1'b1, 6, 2, 1'b1);
    drain_check("mom_empty");
    clear_q();

    // Randomized frames under random backpressure, one at a time.
    rnd_rdy = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NP; i++) pixv[i] = PIX_W'($urandom_range(0, 4095));
      send_frame(1'($urandom_range(0, 1)), $urandom_range(0, NP - 1), $urandom_range(0, NP - 1), 1'b1);
      drain_check("random");
      clear_q();
    end
    rnd_rdy = 1'b0;
    m_axis_tready = 1'b1;
    @(posedge master_clock); #1;

    // Burst of three frames: only the last carries the TLAST word.
    number_of_packet = 16'd2;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NP; i++) pixv[i] = PIX_W'($urandom_range(0, 4095));
      send_frame(1'b0, 0, 0, 1'b1);
    end
    drain_check("burst3");
    clear_q();
    number_of_packet = 16'd0;

    // Stalled sink: first frame fits, next two are dropped whole.
    m_axis_tready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NP; i++) pixv[i] = PIX_W'($urandom_range(0, 4095));
      send_frame(1'b0, 0, 0, f == 0);
    end
    chk("drop_count", 64'(drop_count), 64'd2);
    chk("overflow", 64'(overflow), 64'd1);
    chk("frame_count", 64'(frame_count), 64'(fc_m));
    m_axis_tready = 1'b1;
    drain_check("drop_drain");
    clear_q();

    // Reset in the middle of a raw frame with words still queued.
    m_axis_tready = 1'b0;
    for (int i = 0; i < NP; i++) pixv[i] = PIX_W'($urandom_range(0, 4095));
    mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pix_valid = 1'b1;
      pix_index = IDX_W'(i);
      pix_data  = pixv[i];
      @(posedge master_clock); #1;
    end
    chk("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
    resetn = 1'b0;
    pix_valid = 1'b0;
    @(posedge master_clock); #1;
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_frame_count", 64'(frame_count), 64'd0);
    chk("midrst_drop_count", 64'(drop_count), 64'd0);
    chk("midrst_overflow", 64'(overflow), 64'd0);
    @(posedge master_clock); #1;
    resetn = 1'b1;
    rel_cyc = cyc;
    m_axis_tready = 1'b1;
    clear_q();
    fc_m = '0;
    burst_m = 0;
    for (int i = 0; i < NP; i++) pixv[i] = PIX_W'($urandom_range(0, 4095));
    send_frame(1'b0, 0, 0, 1'b1);
    drain_check("after_reset");
    if (obs_q.size() == 9) begin
      chk("after_reset_hdr", 64'(obs_q[0]), 64'h0_AAAAAAAA);
      chk("after_reset_fcnt", 64'(obs_q[1]), 64'h0);
    end
    clear_q();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
